// File: rtl/bitstream_pkg.sv
// Shared definitions for the bitstream serializer: FSM encoding and counter sizing.
package bitstream_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Width needed to count 0..range-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned range);
    if (range <= 2) begin
      return 1;
    end
    return $clog2(range);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit clock divider: counts CLKS_PER_BIT clocks and strobes on the last one.
module bit_timer
  import bitstream_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic enable,
  input  logic restart,
  output logic oSTROBE
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oSTROBE = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/bitstream_serializer.sv
// Parallel-to-serial stage with a one-word holding buffer so consecutive words stream gap-free.
module bitstream_serializer
  import bitstream_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          IDLE_LEVEL   = 1'b0
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [WIDTH-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic             oOUT,
  output logic             oSTROBE,
  output logic             oDONE,
  output logic             oBUSY
);

  if (WIDTH < 2) begin : g_bad_width
    $error("bitstream_serializer: WIDTH must be >= 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("bitstream_serializer: CLKS_PER_BIT must be >= 1");
  end

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             out_q, out_d;
  logic             ready_q;
  logic             xfer;
  logic             strobe;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] shifted;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign xfer     = iVALID && ready_q;
  assign last_bit = strobe && (bit_q == BIT_LAST);
  assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .enable (state_q == ST_SHIFT),
    .restart(load),
    .oSTROBE(strobe)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    out_d       = out_q;
    load        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          shift_d = iDATA;
          out_d   = head(iDATA);
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          bit_d = '0;
          // Buffered word wins; a direct load is only possible with the buffer empty.
          if (hold_full_q) begin
            load        = 1'b1;
            shift_d     = hold_q;
            out_d       = head(hold_q);
            hold_full_d = 1'b0;
          end else if (xfer) begin
            load    = 1'b1;
            shift_d = iDATA;
            out_d   = head(iDATA);
          end else begin
            out_d   = IDLE_LEVEL;
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            hold_d      = iDATA;
            hold_full_d = 1'b1;
          end
          if (strobe) begin
            shift_d = shifted;
            out_d   = head(shifted);
            bit_d   = bit_q + BW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      out_q       <= IDLE_LEVEL;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      out_q       <= out_d;
      ready_q     <= !hold_full_d;
    end
  end

  assign oREADY  = ready_q;
  assign oOUT    = out_q;
  assign oSTROBE = strobe;
  assign oDONE   = last_bit;
  assign oBUSY   = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_bitstream_serializer.sv
// Randomized scoreboard bench for two serializer configurations (1 and 4 clocks per bit).
module tb_bitstream_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic v;
    logic last;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valid = '0;
  logic [1:0][W-1:0] data = '0;
  logic [1:0] ready, out, strobe, done, busy;

  int total = 0;
  int bad = 0;
  ent_t sbq[2][$];
  int cyc[2];

  always #5 clk = ~clk;

  bitstream_serializer #(
    .WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .iCLK(clk), .iRST(rst_n), .iDATA(data[0]), .iVALID(valid[0]), .oREADY(ready[0]),
    .oOUT(out[0]), .oSTROBE(strobe[0]), .oDONE(done[0]), .oBUSY(busy[0])
  );

  bitstream_serializer #(
    .WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut_b (
    .iCLK(clk), .iRST(rst_n), .iDATA(data[1]), .iVALID(valid[1]), .oREADY(ready[1]),
    .oOUT(out[1]), .oSTROBE(strobe[1]), .oDONE(done[1]), .oBUSY(busy[1])
  );

  function automatic int cpb_of(input int id);
    return (id == 0) ? 1 : 4;
  endfunction

  function automatic bit msb_of(input int id);
    return (id == 0);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: each accepted word becomes WIDTH bit entries in transmission order.
  task automatic push_word(input int id, input logic [W-1:0] w);
    ent_t e;
    int idx;
    for (int k = 0; k < W; k++) begin
      idx = msb_of(id) ? (W - 1 - k) : k;
      e.v = w[idx];
      e.last = (k == W - 1);
      sbq[id].push_back(e);
    end
  endtask

  task automatic mon(input int id);
    int words;
    ent_t h;
    logic exp_s;
    words = 0;
    for (int i = 0; i < sbq[id].size(); i++) begin
      if (sbq[id][i].last) words++;
    end
    // Buffer is full exactly when a second word is queued behind the one in flight.
    chk($sformatf("ready%0d", id), ready[id], words <= 1);
    if (sbq[id].size() == 0) begin
      cyc[id] = 0;
      chk($sformatf("busy%0d", id), busy[id], 1'b0);
      chk($sformatf("idle_out%0d", id), out[id], 1'b0);
      chk($sformatf("idle_strobe%0d", id), strobe[id], 1'b0);
      chk($sformatf("idle_done%0d", id), done[id], 1'b0);
    end else begin
      h = sbq[id][0];
      cyc[id]++;
      exp_s = (cyc[id] == cpb_of(id));
      chk($sformatf("busy%0d", id), busy[id], 1'b1);
      chk($sformatf("out%0d", id), out[id], h.v);
      chk($sformatf("strobe%0d", id), strobe[id], exp_s);
      chk($sformatf("done%0d", id), done[id], exp_s && h.last);
      if (exp_s) begin
        void'(sbq[id].pop_front());
        cyc[id] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int id, input logic [W-1:0] w, input bit scramble);
    bit took;
    logic [W-1:0] cur;
    took = 1'b0;
    cur = w;
    valid[id] = 1'b1;
    data[id] = cur;
    for (int n = 0; n < 400 && !took; n++) begin
      @(negedge clk);
      took = ready[id];
      if (!took && scramble) begin
        cur = W'($urandom);
        data[id] = cur;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("accept%0d", id), took, 1'b1);
    if (took) push_word(id, cur);
    valid[id] = 1'b0;
    data[id] = W'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data[0] = W'($urandom);
      data[1] = W'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc[0] = 0;
    cyc[1] = 0;
    #1;
    chk("rst_out", out[0], 1'b0);
    chk("rst_ready", ready[0], 1'b0);
    chk("rst_busy", busy[1], 1'b0);
    #20 rst_n = 1'b1;
    #1;
    chk("rel_ready_pre", ready[0], 1'b0);
    @(posedge clk);
    #1;
    chk("rel_ready_post", ready[0], 1'b1);
    chk("rel_ready_post_b", ready[1], 1'b1);

    send(0, 8'hA5, 1'b0);
    idle(10);

    send(0, 8'h05, 1'b0);
    send(0, 8'h40, 1'b0);
    send(0, 8'h3C, 1'b0);
    idle(30);

    send(1, 8'h01, 1'b0);
    idle(40);

    send(0, 8'hF0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("eow_done", done[0], 1'b1);
    chk("eow_ready", ready[0], 1'b1);
    send(0, 8'h0F, 1'b0);
    idle(12);

    send(0, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    cyc[0] = 0;
    cyc[1] = 0;
    #1;
    chk("mid_rst_out", out[0], 1'b0);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_ready", ready[0], 1'b0);
    chk("mid_rst_strobe", strobe[0], 1'b0);
    chk("mid_rst_done", done[0], 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rerel_ready_pre", ready[0], 1'b0);
    @(posedge clk);
    #1;
    chk("rerel_ready_post", ready[0], 1'b1);
    chk("rerel_busy", busy[0], 1'b0);
    send(0, 8'h81, 1'b0);
    idle(12);

    for (int i = 0; i < 30; i++) begin
      idle(int'($urandom_range(0, 3)));
      send(0, W'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) begin
      idle(int'($urandom_range(0, 3)));
      send(1, W'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 3000; n++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", (sbq[0].size() == 0) && (sbq[1].size() == 0), 1'b1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
